// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array operand feeder.
//   N         : array dimension (rows = cols)
//   DW        : operand element width
//   DRAIN_CYC : default zero-fill cycles after the last operand (must be >= N)
//   FEED_LEN  : number of skewed operand cycles (2N-1)
//   LW/AW     : row/col index width and flat element address width
package systolic_pkg;
    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int DRAIN_CYC = 4;
    localparam int FEED_LEN  = 2 * N - 1;
    localparam int LW        = $clog2(N);
    localparam int AW        = 2 * LW;
    // Flat address = row*N + col, so the row lives in the upper LW bits.
    localparam int ROW_LSB   = LW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_DRAIN,
        ST_FIN
    } state_e;

    // Counter only ever reaches max(FEED_LEN, drain) - 1.
    function automatic int cnt_width(int drain);
        int m;
        m = (FEED_LEN > drain) ? FEED_LEN : drain;
        return (m > 2) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/systolic_feeder_if.sv
// Operand load / control / operand output bundle of the feeder.
//   master : operand writer and sequencer (testbench or host)
//   slave  : the feeder itself
interface systolic_feeder_if;
    logic                            wr_en;
    logic                            wr_sel;
    logic [systolic_pkg::AW-1:0]     wr_addr;
    logic [systolic_pkg::DW-1:0]     wr_data;
    logic                            start;
    logic                            busy;
    logic                            done;
    logic                            arr_clr;
    logic [systolic_pkg::DW-1:0]     west0, west1, west2, west3;
    logic [systolic_pkg::DW-1:0]     north0, north1, north2, north3;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, arr_clr,
        input  west0, west1, west2, west3, north0, north1, north2, north3
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, arr_clr,
        output west0, west1, west2, west3, north0, north1, north2, north3
    );
endinterface

// File: rtl/systolic_feeder_skew_mux.sv
// Picks one element of a matrix row/column for the current feed step.
//   t_i    : feed step
//   vec_i  : the row (west lane) or column (north lane) of the matrix
//   elem_o : vec_i[t_i - IDX] when that index is in range, else 0
module skew_mux
    import systolic_pkg::*;
#(
    parameter int IDX = 0,
    parameter int CW  = 3
) (
    input  logic [CW-1:0]          t_i,
    input  logic [N-1:0][DW-1:0]   vec_i,
    output logic [DW-1:0]          elem_o
);
    always_comb begin
        elem_o = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(t_i) == IDX + k) elem_o = vec_i[k];
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 output-stationary systolic array.
// Holds A and B in register files, and on start emits a clear pulse, a skewed
// 2N-1 cycle operand stream, DRAIN zero cycles and a one-cycle done.
//   clk, rst : clock, synchronous active-low reset
//   bus      : write port (wr_en/wr_sel/wr_addr/wr_data), start, busy, done,
//              arr_clr, west0..3 (row operands), north0..3 (column operands)
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DRAIN = DRAIN_CYC
) (
    input  logic              clk,
    input  logic              rst,
    systolic_feeder_if.slave  bus
);
    localparam int CW = cnt_width(DRAIN);

    state_e                         st_q, st_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [N-1:0][N-1:0][DW-1:0]    a_q, b_q;     // [row][col]
    logic [N-1:0][N-1:0][DW-1:0]    b_col;        // B transposed: [col][row]
    logic [N-1:0][DW-1:0]           w_mux, n_mux, w_q, n_q;
    logic                           clr_q, busy_q, done_q;

    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        case (st_q)
            ST_IDLE:  if (bus.start) st_d = ST_CLR;
            ST_CLR:   st_d = ST_FEED;
            ST_FEED:
                if (cnt_q == CW'(FEED_LEN - 1)) st_d = ST_DRAIN;
                else                            cnt_d = cnt_q + CW'(1);
            ST_DRAIN:
                if (cnt_q == CW'(DRAIN - 1)) st_d = ST_FIN;
                else                         cnt_d = cnt_q + CW'(1);
            ST_FIN:   st_d = ST_IDLE;
            default:  st_d = ST_IDLE;
        endcase
    end

    // Lanes look at the next-state step so the registered outputs line up
    // with the state they belong to.
    for (genvar g = 0; g < N; g++) begin : g_lane
        for (genvar r = 0; r < N; r++) begin : g_tr
            assign b_col[g][r] = b_q[r][g];
        end
        skew_mux #(.IDX(g), .CW(CW)) u_west (
            .t_i(cnt_d), .vec_i(a_q[g]), .elem_o(w_mux[g])
        );
        skew_mux #(.IDX(g), .CW(CW)) u_north (
            .t_i(cnt_d), .vec_i(b_col[g]), .elem_o(n_mux[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            w_q    <= '0;
            n_q    <= '0;
            clr_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            // Writes only land in IDLE so the files are frozen during a feed.
            if (st_q == ST_IDLE && bus.wr_en) begin
                if (bus.wr_sel)
                    b_q[bus.wr_addr[AW-1:ROW_LSB]][bus.wr_addr[ROW_LSB-1:0]] <= bus.wr_data;
                else
                    a_q[bus.wr_addr[AW-1:ROW_LSB]][bus.wr_addr[ROW_LSB-1:0]] <= bus.wr_data;
            end
            clr_q  <= (st_d == ST_CLR);
            busy_q <= (st_d == ST_CLR) || (st_d == ST_FEED) || (st_d == ST_DRAIN);
            done_q <= (st_d == ST_FIN);
            w_q    <= (st_d == ST_FEED) ? w_mux : '0;
            n_q    <= (st_d == ST_FEED) ? n_mux : '0;
        end
    end

    assign bus.arr_clr = clr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.west0   = w_q[0];
    assign bus.west1   = w_q[1];
    assign bus.west2   = w_q[2];
    assign bus.west3   = w_q[3];
    assign bus.north0  = n_q[0];
    assign bus.north1  = n_q[1];
    assign bus.north2  = n_q[2];
    assign bus.north3  = n_q[3];
endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
    import systolic_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if bus();
    systolic_feeder #(.DRAIN(DRAIN_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    int ma[4][4];
    int mb[4][4];
    logic [66:0] act[0:15];
    logic [66:0] act1[0:15];
    int acc_snap[4][4];

    logic [DW-1:0] wv[4];
    logic [DW-1:0] nv[4];
    assign wv[0] = bus.west0;  assign wv[1] = bus.west1;
    assign wv[2] = bus.west2;  assign wv[3] = bus.west3;
    assign nv[0] = bus.north0; assign nv[1] = bus.north1;
    assign nv[2] = bus.north2; assign nv[3] = bus.north3;

    // Behavioural 4x4 output-stationary array fed by the DUT.
    int aw[4][4];
    int an[4][4];
    int acc[4][4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc[i][j] <= bus.arr_clr ? 0 : acc[i][j] + aw[i][j] * an[i][j];
                if (j == 0) aw[i][j] <= int'(wv[i]);
                else        aw[i][j] <= aw[i][j-1];
                if (i == 0) an[i][j] <= int'(nv[j]);
                else        an[i][j] <= an[i-1][j];
            end
        end
    end

    // {arr_clr, busy, done, west0..3, north0..3}
    function automatic logic [66:0] snap();
        return {bus.arr_clr, bus.busy, bus.done, bus.west0, bus.west1, bus.west2,
                bus.west3, bus.north0, bus.north1, bus.north2, bus.north3};
    endfunction

    // Expected outputs for cycle c after the start edge.
    function automatic logic [66:0] exp_vec(int c);
        logic [DW-1:0] w[4];
        logic [DW-1:0] n[4];
        int t;
        t = c - 2;
        for (int i = 0; i < 4; i++) begin
            w[i] = '0;
            n[i] = '0;
            if (t >= 0 && t <= 6 && t - i >= 0 && t - i <= 3) begin
                w[i] = DW'(ma[i][t-i]);
                n[i] = DW'(mb[t-i][i]);
            end
        end
        return {(c == 1), (c >= 1 && c <= 12), (c == 13),
                w[0], w[1], w[2], w[3], n[0], n[1], n[2], n[3]};
    endfunction

    task automatic wr(input logic sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 4'(addr);
        bus.wr_data = 8'(data);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                wr(1'b0, 4*i + j, ma[i][j]);
                wr(1'b1, 4*i + j, mb[i][j]);
            end
    endtask

    task automatic set_default_mats();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 4*i + j + 1;
                mb[i][j] = 16 + 4*i + j;
            end
    endtask

    // Called at a negedge. Starts a sequence and records cycles 1..14.
    // st_cyc / wr_cyc: cycle during which start / wr_en is driven (0 = with start).
    task automatic run_seq(input int st_cyc, input int wr_cyc, input logic wsel,
                           input int waddr, input int wdata);
        bus.wr_sel  = wsel;
        bus.wr_addr = 4'(waddr);
        bus.wr_data = 8'(wdata);
        bus.start   = 1'b1;
        bus.wr_en   = (wr_cyc == 0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            act[c] = snap();
            if (c == 13) acc_snap = acc;
            bus.start = (c == st_cyc);
            bus.wr_en = (c == wr_cyc);
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (snap() !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outs got %h exp 0", snap());
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        set_default_mats();
        load_all();
        run_seq(-1, -1, 1'b0, 0, 0);
        n_tests++;
        if (act[1][66] !== 1'b1 || act[1][65] !== 1'b1) begin
            n_fail++; $display("FAIL clr_c1 got %h exp clr=1 busy=1", act[1][66:64]);
        end
        n_tests++;
        if (act[2][63:0] !== {8'd1, 24'd0, 8'd16, 24'd0}) begin
            n_fail++; $display("FAIL t0_ops got %h", act[2][63:0]);
        end
        n_tests++;
        if (act[5][47:40] !== 8'd10 || act[5][39:32] !== 8'd13 || act[5][7:0] !== 8'd19) begin
            n_fail++; $display("FAIL t3_ops got w2=%0d w3=%0d n3=%0d exp 10 13 19",
                               act[5][47:40], act[5][39:32], act[5][7:0]);
        end
        n_tests++;
        if (act[8][63:0] !== {24'd0, 8'd16, 24'd0, 8'd31}) begin
            n_fail++; $display("FAIL t6_ops got %h", act[8][63:0]);
        end
        n_tests++;
        if (act[12][64] !== 1'b0 || act[13][64] !== 1'b1 || act[14][64] !== 1'b0 ||
            act[13][65] !== 1'b0) begin
            n_fail++; $display("FAIL done_c13 got done12..14=%b%b%b exp 010",
                               act[12][64], act[13][64], act[14][64]);
        end
        for (int c = 1; c <= 14; c++) begin
            n_tests++;
            if (act[c] !== exp_vec(c)) begin
                n_fail++; $display("FAIL stream c%0d got %h exp %h", c, act[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_array();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                wr(1'b0, 4*i + j, ma[i][j]);
            end
        run_seq(-1, -1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                n_tests++;
                if (acc_snap[i][j] !== 16 + 4*i + j) begin
                    n_fail++; $display("FAIL array_c%0d%0d got %0d exp %0d",
                                       i, j, acc_snap[i][j], 16 + 4*i + j);
                end
            end
    endtask

    task automatic test_ignored();
        set_default_mats();
        load_all();
        // start at FEED t=2, write A[0]=0xAA during DRAIN: both ignored
        run_seq(4, 10, 1'b0, 0, 8'hAA);
        for (int c = 1; c <= 14; c++) begin
            n_tests++;
            if (act[c] !== exp_vec(c)) begin
                n_fail++; $display("FAIL ignored c%0d got %h exp %h", c, act[c], exp_vec(c));
            end
        end
        run_seq(-1, -1, 1'b0, 0, 0);
        n_tests++;
        if (act[2][63:56] !== 8'd1) begin
            n_fail++; $display("FAIL regfile_kept got %0d exp 1", act[2][63:56]);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b0;                 // sampled at the edge ending FEED t=4
        @(negedge clk);
        n_tests++;
        if (snap() !== 67'd0) begin
            n_fail++; $display("FAIL midrst_outs got %h exp 0", snap());
        end
        rst = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle got done/busy activity exp none");
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
        run_seq(-1, -1, 1'b0, 0, 0);
        for (int c = 1; c <= 14; c++) begin
            n_tests++;
            if (act[c] !== exp_vec(c)) begin
                n_fail++; $display("FAIL zero_feed c%0d got %h exp %h", c, act[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_write_start();
        set_default_mats();
        load_all();
        ma[1][1] = 8'h7F;
        run_seq(-1, 0, 1'b0, 5, 8'h7F);
        n_tests++;
        if (act[4][55:48] !== 8'h7F) begin
            n_fail++; $display("FAIL wr_start got %h exp 7f", act[4][55:48]);
        end
        for (int c = 1; c <= 14; c++) begin
            n_tests++;
            if (act[c] !== exp_vec(c)) begin
                n_fail++; $display("FAIL wr_stream c%0d got %h exp %h", c, act[c], exp_vec(c));
            end
        end
    endtask

    task automatic test_back_to_back();
        run_seq(13, -1, 1'b0, 0, 0);   // start during FIN must be ignored
        act1 = act;
        run_seq(-1, -1, 1'b0, 0, 0);   // started the cycle right after FIN
        for (int c = 1; c <= 14; c++) begin
            n_tests++;
            if (act1[c] !== exp_vec(c)) begin
                n_fail++; $display("FAIL b2b_first c%0d got %h exp %h", c, act1[c], exp_vec(c));
            end
            n_tests++;
            if (act[c] !== exp_vec(c)) begin
                n_fail++; $display("FAIL b2b_second c%0d got %h exp %h", c, act[c], exp_vec(c));
            end
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        rst         = 1'b0;
        test_reset();
        test_stream();
        test_array();
        test_ignored();
        test_mid_reset();
        test_write_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
